// File: rtl/fw_ip_cfg_pkg.sv
// Shared types and constants for the FW configuration shift-chain IP.
package fw_ip_cfg_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD} cfg_state_e;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERR     = 2;
  localparam int ST_MISM    = 3;
  localparam int ST_CNT_LSB = 16;

  localparam int CFG_WORD_W = 24;

  // One-hot decoded op after enable qualification and priority resolution.
  typedef struct packed {
    logic w_reset;
    logic clr;
    logic exec;
    logic w_cfg;
    logic r_cfg;
    logic r_data;
  } cfg_op_t;

  function automatic int nwords(input int bits);
    return (bits + CFG_WORD_W - 1) / CFG_WORD_W;
  endfunction

endpackage

// File: rtl/fw_ip_cfg_clkgen.sv
// Half-period tick generator for the configuration clock; counts only while enabled.
module fw_ip_cfg_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic fw_clk,
  input  logic fw_rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = en && (cnt_q == CW'(CLK_DIV - 1));

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n)        cnt_q <= '0;
    else if (!en || tick) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/fw_ip_cfg_chain.sv
// FW IP that loads the DUT configuration shift chain from a SW-filled word buffer.
// Optional readback/compare path is built when FW_IP_CFG_READBACK_EN is defined.
module fw_ip_cfg_chain
  import fw_ip_cfg_pkg::*;
#(
  parameter int CFG_BITS = 768,
  parameter int CLK_DIV  = 4,
  parameter int LOAD_CYC = 4,
  parameter int RST_CYC  = 16
) (
  input  logic        fw_clk,
  input  logic        fw_rst_n,
  input  logic        fw_dev_id_enable,
  input  logic        fw_op_code_w_reset,
  input  logic        fw_op_code_w_cfg_array_0,
  input  logic        fw_op_code_r_cfg_array_0,
  input  logic        fw_op_code_r_data_array_0,
  input  logic        fw_op_code_w_status_clear,
  input  logic        fw_op_code_w_execute,
  input  logic [23:0] sw_write24_0,
  output logic [31:0] fw_read_data32,
  output logic [31:0] fw_read_status32,
  output logic        fw_config_clk,
  output logic        fw_config_in,
  output logic        fw_config_load,
  output logic        fw_reset_not,
  input  logic        fw_config_out
);

  localparam int NWORDS = nwords(CFG_BITS);
  localparam int PW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int BW     = $clog2(CFG_BITS + 1);
  localparam int LW     = (LOAD_CYC > 1) ? $clog2(LOAD_CYC) : 1;
  localparam int RW     = $clog2(RST_CYC + 1);

  cfg_state_e state_q, state_d;
  cfg_op_t    op;

  logic [NWORDS-1:0][CFG_WORD_W-1:0] buf_q;
  logic [NWORDS*CFG_WORD_W-1:0]      buf_flat;
  logic [CFG_BITS-1:0]               tx_q;
  logic [PW-1:0]                     wptr_q, rptr_q;
  logic [BW-1:0]                     bit_q;
  logic [LW-1:0]                     load_q;
  logic [RW-1:0]                     rst_q;
  logic [31:0]                       rd_q, st_q, st_d, cnt32;
  logic [15:0]                       cnt16;
  logic [CFG_WORD_W-1:0]             rb_word;
  logic cfg_in_q, done_q, err_q, mism_q;
  logic busy, rej, tick, last_bit, load_end, mism_hit;

  assign buf_flat = buf_q;
  assign busy     = (state_q != IDLE);
  assign last_bit = (bit_q == BW'(CFG_BITS));
  assign load_end = (load_q == LW'(LOAD_CYC - 1));

  // Enable qualification and single-winner priority across the op pulses.
  always_comb begin
    op = '0;
    if (fw_dev_id_enable) begin
      if      (fw_op_code_w_reset)        op.w_reset = 1'b1;
      else if (fw_op_code_w_status_clear) op.clr     = 1'b1;
      else if (fw_op_code_w_execute)      op.exec    = 1'b1;
      else if (fw_op_code_w_cfg_array_0)  op.w_cfg   = 1'b1;
      else if (fw_op_code_r_cfg_array_0)  op.r_cfg   = 1'b1;
      else if (fw_op_code_r_data_array_0) op.r_data  = 1'b1;
    end
  end

  assign rej = busy && (op.exec || op.w_cfg || op.r_data);

  fw_ip_cfg_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .fw_clk   (fw_clk),
    .fw_rst_n (fw_rst_n),
    .en       ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)),
    .tick     (tick)
  );

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (op.exec) state_d = SHIFT_LO;
      SHIFT_LO: if (tick)    state_d = SHIFT_HI;
      SHIFT_HI: if (tick)    state_d = last_bit ? LOAD : SHIFT_LO;
      LOAD:     if (load_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    if (op.w_reset) state_d = IDLE;
  end

  // Shift datapath. tx_q rotates one place per launched bit, so after a full
  // shift it holds the launched image again for the next readback compare.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      tx_q     <= '0;
      bit_q    <= '0;
      load_q   <= '0;
      rst_q    <= '0;
      cfg_in_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mism_q   <= 1'b0;
    end else if (op.w_reset) begin
      cfg_in_q <= 1'b0;
      done_q   <= 1'b0;
      rst_q    <= RW'(RST_CYC);
    end else begin
      if (rst_q != '0) rst_q <= rst_q - 1'b1;
      if (op.clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        mism_q <= 1'b0;
      end
      if (rej) err_q <= 1'b1;
      case (state_q)
        IDLE: if (op.exec) begin
          bit_q    <= '0;
          cfg_in_q <= buf_flat[CFG_BITS-1];
          tx_q     <= {buf_flat[CFG_BITS-2:0], buf_flat[CFG_BITS-1]};
        end
        SHIFT_LO: if (tick) bit_q <= bit_q + 1'b1;
        SHIFT_HI: if (tick) begin
          load_q <= '0;
          if (last_bit) cfg_in_q <= 1'b0;
          else begin
            cfg_in_q <= tx_q[CFG_BITS-1];
            tx_q     <= {tx_q[CFG_BITS-2:0], tx_q[CFG_BITS-1]};
          end
        end
        LOAD: begin
          load_q <= load_q + 1'b1;
          if (load_end) begin
            done_q <= 1'b1;
            if (mism_hit) mism_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Word buffer, pointers and SW read data.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      buf_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      rd_q   <= '0;
    end else if (op.clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (op.w_cfg && !busy) begin
        buf_q[wptr_q] <= sw_write24_0;
        wptr_q <= (wptr_q == PW'(NWORDS - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (op.r_cfg || (op.r_data && !busy)) begin
        rd_q   <= {8'h0, op.r_cfg ? buf_q[rptr_q] : rb_word};
        rptr_q <= (rptr_q == PW'(NWORDS - 1)) ? '0 : rptr_q + 1'b1;
      end
    end
  end

`ifdef FW_IP_CFG_READBACK_EN
  logic [CFG_BITS-1:0]          rb_q, prev_q;
  logic [NWORDS*CFG_WORD_W-1:0] rb_pad;
  logic                         prev_vld_q;

  // Chain output is sampled as config_clk rises; the first bit out is the MSB.
  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      rb_q       <= '0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
    end else if (op.w_reset) begin
      prev_vld_q <= 1'b0;
    end else begin
      if (state_q == IDLE && op.exec)   prev_q <= tx_q;
      if (state_q == SHIFT_LO && tick)  rb_q   <= {rb_q[CFG_BITS-2:0], fw_config_out};
      if (state_q == LOAD && load_end)  prev_vld_q <= 1'b1;
    end
  end

  always_comb begin
    rb_pad = '0;
    rb_pad[CFG_BITS-1:0] = rb_q;
  end

  assign rb_word  = rb_pad[rptr_q*CFG_WORD_W +: CFG_WORD_W];
  assign mism_hit = prev_vld_q && (rb_q != prev_q);
`else
  logic unused_cfg_out;
  assign unused_cfg_out = fw_config_out;
  assign rb_word  = '0;
  assign mism_hit = 1'b0;
`endif

  always_comb begin
    cnt32 = 32'(bit_q);
    cnt16 = (cnt32 > 32'h0000_FFFF) ? 16'hFFFF : cnt32[15:0];
    st_d  = '0;
    st_d[31:ST_CNT_LSB] = cnt16;
    st_d[ST_BUSY] = busy;
    st_d[ST_DONE] = done_q;
    st_d[ST_ERR]  = err_q;
    st_d[ST_MISM] = mism_q;
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) st_q <= '0;
    else           st_q <= st_d;
  end

  assign fw_read_data32   = rd_q;
  assign fw_read_status32 = st_q;
  assign fw_config_clk    = (state_q == SHIFT_HI);
  assign fw_config_load   = (state_q != LOAD);
  assign fw_config_in     = cfg_in_q;
  assign fw_reset_not     = (rst_q == '0);

endmodule

// File: tb/tb_fw_ip_cfg_chain.sv
// Directed bench for fw_ip_cfg_chain with a 48-bit serial chain model on the DUT side.
module tb_fw_ip_cfg_chain;

  localparam logic [5:0] OP_RST  = 6'b000001;
  localparam logic [5:0] OP_WCFG = 6'b000010;
  localparam logic [5:0] OP_RCFG = 6'b000100;
  localparam logic [5:0] OP_RDAT = 6'b001000;
  localparam logic [5:0] OP_CLR  = 6'b010000;
  localparam logic [5:0] OP_EXEC = 6'b100000;

  logic        fw_clk = 1'b0;
  logic        fw_rst_n = 1'b0;
  logic        en = 1'b0;
  logic        w_reset = 1'b0, w_cfg = 1'b0, r_cfg = 1'b0, r_data = 1'b0, clr = 1'b0, exec = 1'b0;
  logic [23:0] wdata = '0;
  logic [31:0] rdata, status;
  logic        cfg_clk, cfg_in, cfg_load, reset_not, cfg_out;

  int checks = 0;
  int errors = 0;

  logic [47:0] chain = '0;
  logic [47:0] cap = '0;
  int          edge_cnt = 0;
  int          load_low = 0;

  always #5 fw_clk = ~fw_clk;

  fw_ip_cfg_chain #(.CFG_BITS(48), .CLK_DIV(2), .LOAD_CYC(4), .RST_CYC(16)) dut (
    .fw_clk                    (fw_clk),
    .fw_rst_n                  (fw_rst_n),
    .fw_dev_id_enable          (en),
    .fw_op_code_w_reset        (w_reset),
    .fw_op_code_w_cfg_array_0  (w_cfg),
    .fw_op_code_r_cfg_array_0  (r_cfg),
    .fw_op_code_r_data_array_0 (r_data),
    .fw_op_code_w_status_clear (clr),
    .fw_op_code_w_execute      (exec),
    .sw_write24_0              (wdata),
    .fw_read_data32            (rdata),
    .fw_read_status32          (status),
    .fw_config_clk             (cfg_clk),
    .fw_config_in              (cfg_in),
    .fw_config_load            (cfg_load),
    .fw_reset_not              (reset_not),
    .fw_config_out             (cfg_out)
  );

  // DUT-side chain: shifts toward the MSB, serial output at the far end.
  assign cfg_out = chain[47];
  always @(posedge cfg_clk) begin
    chain    <= {chain[46:0], cfg_in};
    cap      <= {cap[46:0], cfg_in};
    edge_cnt <= edge_cnt + 1;
  end
  always @(posedge fw_clk) if (!cfg_load) load_low <= load_low + 1;

  task automatic pulse(input logic [5:0] ops, input logic [23:0] d, input logic ena);
    @(negedge fw_clk);
    en = ena; wdata = d;
    w_reset = ops[0]; w_cfg = ops[1]; r_cfg = ops[2]; r_data = ops[3]; clr = ops[4]; exec = ops[5];
    @(negedge fw_clk);
    en = 1'b0; w_reset = 1'b0; w_cfg = 1'b0; r_cfg = 1'b0; r_data = 1'b0; clr = 1'b0; exec = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge fw_clk);
      cyc++;
    end while (!status[1] && cyc < 1000);
  endtask

  task automatic wait_cnt(input int target, output int cyc);
    cyc = 0;
    while (status[31:16] != 16'(target) && cyc < 1000) begin
      @(negedge fw_clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge fw_clk);
    checks++;
    if ({cfg_clk, cfg_in, cfg_load, reset_not} !== 4'b0011) begin
      errors++;
      $display("FAIL reset_pins: got %b expected 0011", {cfg_clk, cfg_in, cfg_load, reset_not});
    end
    checks++;
    if (rdata !== 32'h0 || status !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: got data %h status %h expected 0/0", rdata, status);
    end
  endtask

  task automatic test_shift;
    int cyc;
    pulse(OP_WCFG, 24'hA5A5A5, 1'b1);
    pulse(OP_WCFG, 24'h00FFFF, 1'b1);
    edge_cnt = 0; load_low = 0;
    pulse(OP_EXEC, 24'h0, 1'b1);
    wait_done(cyc);
    checks++;
    if (cyc !== 197) begin errors++; $display("FAIL exec_latency: got %0d expected 197", cyc); end
    checks++;
    if (edge_cnt !== 48) begin errors++; $display("FAIL shift_edges: got %0d expected 48", edge_cnt); end
    checks++;
    if (cap !== 48'h00FFFF_A5A5A5) begin errors++; $display("FAIL shift_bits: got %h expected 00ffffa5a5a5", cap); end
    checks++;
    if (load_low !== 4) begin errors++; $display("FAIL load_width: got %0d expected 4", load_low); end
    checks++;
    if (status !== 32'h0030_0002) begin errors++; $display("FAIL shift_status: got %h expected 00300002", status); end
    checks++;
    if (cfg_in !== 1'b0 || cfg_load !== 1'b1) begin
      errors++; $display("FAIL shift_idle_pins: got in %b load %b expected 0 1", cfg_in, cfg_load);
    end
  endtask

  task automatic test_readback;
    int cyc;
    for (int r = 0; r < 2; r++) begin
      pulse(OP_CLR, 24'h0, 1'b1);
      pulse(OP_EXEC, 24'h0, 1'b1);
      wait_done(cyc);
    end
    checks++;
    if (status[3] !== 1'b0) begin errors++; $display("FAIL readback_mismatch: got %b expected 0", status[3]); end
    pulse(OP_RDAT, 24'h0, 1'b1);
    checks++;
`ifdef FW_IP_CFG_READBACK_EN
    if (rdata !== 32'h00A5A5A5) begin errors++; $display("FAIL rdata_w0: got %h expected 00a5a5a5", rdata); end
`else
    if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_w0: got %h expected 0", rdata); end
`endif
    pulse(OP_RDAT, 24'h0, 1'b1);
    checks++;
`ifdef FW_IP_CFG_READBACK_EN
    if (rdata !== 32'h0000FFFF) begin errors++; $display("FAIL rdata_w1: got %h expected 0000ffff", rdata); end
`else
    if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_w1: got %h expected 0", rdata); end
`endif
    // rptr wrapped to word 0 after two reads, whichever build this is
    pulse(OP_RCFG, 24'h0, 1'b1);
    checks++;
    if (rdata !== 32'h00A5A5A5) begin errors++; $display("FAIL rptr_wrap: got %h expected 00a5a5a5", rdata); end
  endtask

  task automatic test_busy_exec;
    int cyc;
    pulse(OP_CLR, 24'h0, 1'b1);
    edge_cnt = 0;
    pulse(OP_EXEC, 24'h0, 1'b1);
    wait_cnt(10, cyc);
    checks++;
    if (cyc >= 1000) begin errors++; $display("FAIL busy_wait10: got timeout expected count 10"); end
    pulse(OP_EXEC, 24'h0, 1'b1);
    @(negedge fw_clk);
    checks++;
    if (status[2:0] !== 3'b101) begin errors++; $display("FAIL busy_err: got %b expected 101", status[2:0]); end
    wait_done(cyc);
    checks++;
    if (edge_cnt !== 48 || status[31:16] !== 16'd48) begin
      errors++; $display("FAIL busy_edges: got %0d/%0d expected 48/48", edge_cnt, status[31:16]);
    end
    repeat (20) @(negedge fw_clk);
    checks++;
    if (edge_cnt !== 48 || status[2:0] !== 3'b110) begin
      errors++; $display("FAIL busy_once: got edges %0d st %b expected 48 110", edge_cnt, status[2:0]);
    end
  endtask

  task automatic test_w_reset;
    int cyc;
    int low;
    pulse(OP_CLR, 24'h0, 1'b1);
    edge_cnt = 0;
    pulse(OP_EXEC, 24'h0, 1'b1);
    wait_cnt(20, cyc);
    pulse(OP_RST, 24'h0, 1'b1);
    checks++;
    if (cfg_clk !== 1'b0 || cfg_load !== 1'b1) begin
      errors++; $display("FAIL wrst_pins: got clk %b load %b expected 0 1", cfg_clk, cfg_load);
    end
    low = 0;
    while (reset_not === 1'b0 && low < 40) begin
      low++;
      @(negedge fw_clk);
    end
    checks++;
    if (low !== 16) begin errors++; $display("FAIL wrst_width: got %0d expected 16", low); end
    checks++;
    if (status !== 32'h0014_0000 || edge_cnt !== 20) begin
      errors++; $display("FAIL wrst_status: got %h edges %0d expected 00140000 20", status, edge_cnt);
    end
  endtask

  task automatic test_wrap;
    pulse(OP_CLR, 24'h0, 1'b1);
    pulse(OP_WCFG, 24'h111111, 1'b1);
    pulse(OP_WCFG, 24'h222222, 1'b1);
    pulse(OP_WCFG, 24'h333333, 1'b1);
    pulse(OP_WCFG, 24'h444444, 1'b0);
    pulse(OP_CLR, 24'h0, 1'b1);
    pulse(OP_RCFG, 24'h0, 1'b1);
    checks++;
    if (rdata !== 32'h00333333) begin errors++; $display("FAIL wrap_w0: got %h expected 00333333", rdata); end
    pulse(OP_RCFG, 24'h0, 1'b1);
    checks++;
    if (rdata !== 32'h00222222) begin errors++; $display("FAIL wrap_w1: got %h expected 00222222", rdata); end
    pulse(OP_RCFG, 24'h0, 1'b1);
    checks++;
    if (rdata !== 32'h00333333) begin errors++; $display("FAIL wrap_w0b: got %h expected 00333333", rdata); end
    // reads without enable leave data and pointer untouched
    pulse(OP_RCFG, 24'h0, 1'b0);
    checks++;
    if (rdata !== 32'h00333333) begin errors++; $display("FAIL no_enable: got %h expected 00333333", rdata); end
  endtask

  task automatic test_async_reset;
    pulse(OP_EXEC, 24'h0, 1'b1);
    repeat (30) @(negedge fw_clk);
    load_low = 0;
    @(posedge fw_clk);
    #2 fw_rst_n = 1'b0;
    #1;
    checks++;
    if ({cfg_clk, cfg_in, cfg_load, reset_not} !== 4'b0011 || status !== 32'h0) begin
      errors++; $display("FAIL async_rst: got pins %b status %h expected 0011 0", {cfg_clk, cfg_in, cfg_load, reset_not}, status);
    end
    @(negedge fw_clk);
    fw_rst_n = 1'b1;
    repeat (250) @(negedge fw_clk);
    checks++;
    if (load_low !== 0 || status !== 32'h0) begin
      errors++; $display("FAIL async_no_load: got load cycles %0d status %h expected 0 0", load_low, status);
    end
  endtask

  initial begin
    repeat (3) @(negedge fw_clk);
    fw_rst_n = 1'b1;
    test_reset();
    test_shift();
    test_readback();
    test_busy_exec();
    test_w_reset();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
